// File: rtl/servo_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_pkg
// Purpose  : Register map offsets, CTRL bit indices and timing helpers shared
//            by the servo PWM bank and its channels.
// Revision : 1.0 - initial release
// ============================================================================
package servo_pwm_pkg;

    localparam int c_ctrl_en   = 0;
    localparam int c_ctrl_ramp = 1;
    localparam int c_ctrl_w    = 2;

    // Shared registers sit directly above the per-channel TARGET block.
    function automatic int off_ctrl(input int num_ch);
        return num_ch;
    endfunction

    function automatic int off_mask(input int num_ch);
        return num_ch + 1;
    endfunction

    function automatic int off_step(input int num_ch);
        return num_ch + 2;
    endfunction

    function automatic int off_status(input int num_ch);
        return num_ch + 3;
    endfunction

    function automatic int step_cyc(input int min_cyc, input int max_cyc, input int pos_w);
        return (max_cyc - min_cyc) >> pos_w;
    endfunction

    function automatic int centre_pos(input int pos_w);
        return 1 << (pos_w - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_pwm_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_bank_if
// Purpose  : Avalon-MM slave bus bundle for the servo PWM bank.
// Revision : 1.0 - initial release
// ============================================================================
interface servo_pwm_bank_if #(
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic              avs_read;
    logic [31:0]       avs_readdata;

    modport master (
        output avs_address,
        output avs_write,
        output avs_writedata,
        output avs_read,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_write,
        input  avs_writedata,
        input  avs_read,
        output avs_readdata
    );
endinterface
`default_nettype wire

// File: rtl/servo_pwm_channel.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_channel
// Purpose  : One servo output: current position, slew limiting at frame
//            boundaries and the registered pulse comparator.
// Revision : 1.0 - initial release
// ============================================================================
module servo_pwm_channel
    import servo_pwm_pkg::*;
#(
    parameter int POS_W    = 8,
    parameter int CNT_W    = 20,
    parameter int MIN_CYC  = 50_000,
    parameter int STEP_CYC = 195
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt,
    input  logic             boundary,
    input  logic [POS_W-1:0] target,
    input  logic [POS_W-1:0] step,
    input  logic             ramp,
    input  logic             enable,
    output logic             pwm,
    output logic             at_target
);

    localparam logic [POS_W-1:0] c_centre = POS_W'(centre_pos(POS_W));

    logic [POS_W-1:0] r_cur;
    logic             r_pwm;
    logic [POS_W-1:0] w_delta;
    logic [POS_W-1:0] w_move;
    logic [POS_W-1:0] w_cur_next;
    logic             w_up;
    logic [CNT_W-1:0] w_width;

    // Move by at most STEP and never past TARGET; STEP == 0 freezes CUR.
    always_comb begin
        w_up    = (target >= r_cur);
        w_delta = w_up ? (target - r_cur) : (r_cur - target);
        w_move  = (step < w_delta) ? step : w_delta;
        if (!ramp) begin
            w_cur_next = target;
        end else if (w_up) begin
            w_cur_next = r_cur + w_move;
        end else begin
            w_cur_next = r_cur - w_move;
        end
    end

    // Full-scale width stays below PERIOD_CYC, so CNT_W bits cannot overflow.
    assign w_width = CNT_W'(MIN_CYC) + (CNT_W'(r_cur) * CNT_W'(STEP_CYC));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur <= c_centre;
            r_pwm <= 1'b0;
        end else begin
            if (boundary) begin
                r_cur <= w_cur_next;
            end
            r_pwm <= enable & (cnt < w_width);
        end
    end

    assign pwm       = r_pwm;
    assign at_target = (r_cur == target);

endmodule
`default_nettype wire

// File: rtl/servo_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_bank
// Purpose  : Multi-channel hobby-servo PWM generator behind an Avalon-MM slave
//            with frame-synchronous position updates and optional ramping.
// Revision : 1.0 - initial release
// ============================================================================
module servo_pwm_bank
    import servo_pwm_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int POS_W      = 8,
    parameter int PERIOD_CYC = 1_000_000,
    parameter int MIN_CYC    = 50_000,
    parameter int MAX_CYC    = 100_000
) (
    input  logic              clk,
    input  logic              reset,
    servo_pwm_bank_if.slave   bus,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              frame_start
);

    localparam int CNT_W            = $clog2(PERIOD_CYC);
    localparam int c_step_cyc       = step_cyc(MIN_CYC, MAX_CYC, POS_W);
    localparam int c_off_ctrl       = off_ctrl(NUM_CH);
    localparam int c_off_mask       = off_mask(NUM_CH);
    localparam int c_off_step       = off_step(NUM_CH);
    localparam int c_off_status     = off_status(NUM_CH);
    localparam logic [POS_W-1:0] c_centre    = POS_W'(centre_pos(POS_W));
    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(PERIOD_CYC - 1);

    logic [POS_W-1:0]    r_target [NUM_CH];
    logic [c_ctrl_w-1:0] r_ctrl;
    logic [NUM_CH-1:0]   r_mask;
    logic [POS_W-1:0]    r_step;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_frame_start;
    logic [31:0]         r_readdata;

    logic [31:0]         w_addr;
    logic                w_boundary;
    logic [NUM_CH-1:0]   w_status;
    logic [31:0]         w_rdata;

    assign w_addr     = 32'(bus.avs_address);
    assign w_boundary = (r_cnt == c_cnt_last);

    // Register writes; STATUS and unmapped offsets fall through untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_target[i] <= c_centre;
            end
            r_ctrl <= '0;
            r_mask <= '1;
            r_step <= POS_W'(1);
        end else if (bus.avs_write) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_addr == 32'(i)) begin
                    r_target[i] <= bus.avs_writedata[POS_W-1:0];
                end
            end
            if (w_addr == 32'(c_off_ctrl)) begin
                r_ctrl <= bus.avs_writedata[c_ctrl_w-1:0];
            end
            if (w_addr == 32'(c_off_mask)) begin
                r_mask <= bus.avs_writedata[NUM_CH-1:0];
            end
            if (w_addr == 32'(c_off_step)) begin
                r_step <= bus.avs_writedata[POS_W-1:0];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_addr == 32'(i)) begin
                w_rdata = 32'(r_target[i]);
            end
        end
        if (w_addr == 32'(c_off_ctrl)) begin
            w_rdata = 32'(r_ctrl);
        end
        if (w_addr == 32'(c_off_mask)) begin
            w_rdata = 32'(r_mask);
        end
        if (w_addr == 32'(c_off_step)) begin
            w_rdata = 32'(r_step);
        end
        if (w_addr == 32'(c_off_status)) begin
            w_rdata = 32'(w_status);
        end
    end

    // Read data is captured once per read and held until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (bus.avs_read) begin
            r_readdata <= w_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt         <= w_boundary ? '0 : (r_cnt + CNT_W'(1));
            r_frame_start <= w_boundary;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        servo_pwm_channel #(
            .POS_W    (POS_W),
            .CNT_W    (CNT_W),
            .MIN_CYC  (MIN_CYC),
            .STEP_CYC (c_step_cyc)
        ) u_channel (
            .clk       (clk),
            .reset     (reset),
            .cnt       (r_cnt),
            .boundary  (w_boundary),
            .target    (r_target[g]),
            .step      (r_step),
            .ramp      (r_ctrl[c_ctrl_ramp]),
            .enable    (r_ctrl[c_ctrl_en] & r_mask[g]),
            .pwm       (pwm_out[g]),
            .at_target (w_status[g])
        );
    end

    assign bus.avs_readdata = r_readdata;
    assign frame_start      = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_servo_pwm_bank
// Purpose  : Self-checking bench: per-cycle reference model plus measured
//            pulse widths against hand-computed frame values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_bank;

    localparam int NUM_CH = 4;
    localparam int PERIOD = 1000;

    logic             clk = 1'b0;
    logic             reset;
    logic [NUM_CH-1:0] pwm_out;
    logic             frame_start;

    servo_pwm_bank_if #(.ADDR_W(3)) bus ();

    servo_pwm_bank #(
        .NUM_CH(NUM_CH), .POS_W(4), .PERIOD_CYC(PERIOD), .MIN_CYC(100), .MAX_CYC(200)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .pwm_out(pwm_out), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: registers as plain integers, outputs from the frame rules.
    int          m_cnt;
    int          m_cur [NUM_CH];
    int          m_tgt [NUM_CH];
    int          m_ctrl, m_mask, m_step;
    logic [3:0]  e_pwm;
    logic        e_fs;
    logic [31:0] e_rd;

    function automatic logic [31:0] reg_value(input int a);
        logic [31:0] v;
        v = 0;
        if (a < NUM_CH) v = m_tgt[a];
        else if (a == 4) v = m_ctrl;
        else if (a == 5) v = m_mask;
        else if (a == 6) v = m_step;
        else if (a == 7) for (int i = 0; i < NUM_CH; i++) if (m_cur[i] == m_tgt[i]) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int ramp_next(input int cur, input int tgt);
        int diff;
        if ((m_ctrl & 2) == 0) return tgt;
        diff = tgt - cur;
        if (diff > 0) return cur + ((m_step < diff) ? m_step : diff);
        if (diff < 0) return cur - ((m_step < -diff) ? m_step : -diff);
        return cur;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_ctrl = 0; m_mask = 15; m_step = 1;
        for (int i = 0; i < NUM_CH; i++) begin m_cur[i] = 8; m_tgt[i] = 8; end
        e_pwm = 0; e_fs = 0; e_rd = 0;
    endtask

    task automatic model_step();
        int a;
        a = int'(bus.avs_address);
        for (int i = 0; i < NUM_CH; i++)
            e_pwm[i] = ((m_ctrl & 1) != 0) && (((m_mask >> i) & 1) != 0) && (m_cnt < 100 + 6 * m_cur[i]);
        e_fs = (m_cnt == PERIOD - 1);
        if (bus.avs_read) e_rd = reg_value(a);
        if (m_cnt == PERIOD - 1)
            for (int i = 0; i < NUM_CH; i++) m_cur[i] = ramp_next(m_cur[i], m_tgt[i]);
        m_cnt = (m_cnt + 1) % PERIOD;
        if (bus.avs_write) begin
            if (a < NUM_CH) m_tgt[a] = int'(bus.avs_writedata[3:0]);
            else if (a == 4) m_ctrl = int'(bus.avs_writedata[1:0]);
            else if (a == 5) m_mask = int'(bus.avs_writedata[3:0]);
            else if (a == 6) m_step = int'(bus.avs_writedata[3:0]);
        end
    endtask

    always @(posedge clk) begin
        if (reset) model_reset();
        else       model_step();
    end

    always @(negedge clk) begin
        check("model_pwm_out", 32'(pwm_out), 32'(e_pwm));
        check("model_frame_start", 32'(frame_start), 32'(e_fs));
        check("model_readdata", bus.avs_readdata, e_rd);
    end

    // ---------------------------------------------------------------- drivers
    int          meas [NUM_CH];
    logic [31:0] rd_val;

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.avs_write = 1'b1; bus.avs_address = a; bus.avs_writedata = d;
        @(negedge clk);
        bus.avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.avs_read = 1'b1; bus.avs_address = a;
        @(negedge clk);
        bus.avs_read = 1'b0;
        d = bus.avs_readdata;
    endtask

    task automatic sync_frame();
        int n;
        n = 0;
        while (!frame_start && n < 2 * PERIOD + 100) begin @(negedge clk); n++; end
        if (!frame_start) check("frame_sync_timeout", 32'(n), 32'(PERIOD));
    endtask

    // Measures one full frame; optional single write and read at given cnt slots.
    task automatic run_frame(input int wr_at, input logic [2:0] wa, input logic [31:0] wd,
                             input int rd_at, input logic [2:0] ra);
        int fs_seen;
        sync_frame();
        fs_seen = 0;
        for (int i = 0; i < NUM_CH; i++) meas[i] = 0;
        for (int j = 0; j < PERIOD; j++) begin
            for (int i = 0; i < NUM_CH; i++) if (pwm_out[i]) meas[i]++;
            if (frame_start) fs_seen++;
            if (rd_at >= 0 && j == rd_at + 1) rd_val = bus.avs_readdata;
            bus.avs_write = (j == wr_at);
            if (j == wr_at) begin bus.avs_address = wa; bus.avs_writedata = wd; end
            bus.avs_read = (j == rd_at);
            if (j == rd_at) bus.avs_address = ra;
            @(negedge clk);
        end
        bus.avs_write = 1'b0; bus.avs_read = 1'b0;
        check("frame_start_per_frame", 32'(fs_seen), 32'd1);
    endtask

    task automatic expect_w(input string tag, input int w0, input int w1, input int w2, input int w3);
        check({tag, "_ch0"}, 32'(meas[0]), 32'(w0));
        check({tag, "_ch1"}, 32'(meas[1]), 32'(w1));
        check({tag, "_ch2"}, 32'(meas[2]), 32'(w2));
        check({tag, "_ch3"}, 32'(meas[3]), 32'(w3));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int n;
        reset = 1'b1;
        bus.avs_write = 0; bus.avs_read = 0; bus.avs_address = 0; bus.avs_writedata = 0;
        repeat (3) @(negedge clk);
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_fs", 32'(frame_start), 32'd0);
        check("reset_rdata", bus.avs_readdata, 32'd0);
        reset = 1'b0;
        bus_read(3'd0, d); check("reset_target0", d, 32'd8);
        bus_read(3'd4, d); check("reset_ctrl", d, 32'd0);
        bus_read(3'd5, d); check("reset_mask", d, 32'd15);
        bus_read(3'd6, d); check("reset_step", d, 32'd1);
        bus_read(3'd7, d); check("reset_status", d, 32'd15);

        bus_write(3'd4, 32'd1);
        run_frame(-1, 0, 0, -1, 0);   expect_w("en_centre", 148, 148, 148, 148);
        run_frame(300, 3'd2, 32'd15, -1, 0); expect_w("tgt2_cur_frame", 148, 148, 148, 148);
        run_frame(500, 3'd0, 32'd0, -1, 0);  expect_w("tgt2_next_frame", 148, 148, 190, 148);
        run_frame(-1, 0, 0, -1, 0);   expect_w("tgt0_zero", 100, 148, 190, 148);

        bus_write(3'd4, 32'd3); bus_write(3'd6, 32'd2); bus_write(3'd1, 32'd15);
        run_frame(-1, 0, 0, 5, 3'd7); expect_w("ramp1", 100, 160, 190, 148);
        check("ramp1_status", rd_val, 32'hD);
        run_frame(-1, 0, 0, -1, 0);   expect_w("ramp2", 100, 172, 190, 148);
        run_frame(-1, 0, 0, 5, 3'd7); expect_w("ramp3", 100, 184, 190, 148);
        check("ramp3_status", rd_val, 32'hD);
        run_frame(-1, 0, 0, 5, 3'd7); expect_w("ramp4", 100, 190, 190, 148);
        check("ramp4_status", rd_val, 32'hF);
        run_frame(-1, 0, 0, -1, 0);   expect_w("ramp5", 100, 190, 190, 148);

        run_frame(50, 3'd5, 32'hA, -1, 0);   expect_w("mask_midpulse", 51, 190, 51, 148);
        run_frame(999, 3'd5, 32'hF, -1, 0);  expect_w("mask_frame", 0, 190, 0, 148);
        run_frame(0, 3'd4, 32'd1, -1, 0);    expect_w("unmask", 100, 190, 190, 148);
        run_frame(999, 3'd3, 32'd0, -1, 0);  expect_w("bnd_write", 100, 190, 190, 148);
        run_frame(-1, 0, 0, 5, 3'd7);        expect_w("bnd_write_next", 100, 190, 190, 148);
        check("bnd_write_status", rd_val, 32'h7);
        run_frame(-1, 0, 0, 5, 3'd7);        expect_w("bnd_write_applied", 100, 190, 190, 100);
        check("bnd_write_status2", rd_val, 32'hF);

        repeat (50) @(negedge clk);
        check("pre_reset_pwm_high", 32'(pwm_out), 32'hF);
        reset = 1'b1;
        @(negedge clk);
        check("midframe_reset_pwm", 32'(pwm_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!frame_start && n < 2 * PERIOD);
        check("first_fs_after_release", 32'(n), 32'(PERIOD));
        bus_read(3'd3, d); check("post_reset_target3", d, 32'd8);
        bus_read(3'd4, d); check("post_reset_ctrl", d, 32'd0);
        bus_read(3'd6, d); check("post_reset_step", d, 32'd1);
        bus_write(3'd4, 32'd1);
        run_frame(-1, 0, 0, -1, 0);   expect_w("post_reset_frame", 148, 148, 148, 148);

        // Randomized traffic; the per-cycle model comparison does the checking.
        for (int k = 0; k < 20000; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            bus.avs_write = 1'b0; bus.avs_read = 1'b0; reset = 1'b0;
            if (r < 8) begin
                bus.avs_write = 1'b1;
                bus.avs_address = 3'($urandom_range(0, 7));
                bus.avs_writedata = $urandom;
            end else if (r < 18) begin
                bus.avs_read = 1'b1;
                bus.avs_address = 3'($urandom_range(0, 7));
            end else if (r == 99 && $urandom_range(0, 49) == 0) begin
                reset = 1'b1;
            end
            @(negedge clk);
        end
        bus.avs_write = 1'b0; bus.avs_read = 1'b0; reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
